accel_axil_bridge: RTL
======================

# accel_axil_bridge

AXI4-Lite slave to accelerator register-port bridge. It sits between the Cortex-A53 interconnect and an accelerator's register bank, and is the initiator side of that bank's port. It serialises AXI reads and writes into single-cycle `oe` and `we` strobes. It absorbs the bank's one-cycle registered read latency and returns AXI responses.

## Interface
- `NUM_REGS`, 16: number of 64-bit registers in the attached bank; used by the range check.
- `AXI_ADDR_W`, 32: AXI address width. Byte address; word index = addr[18:3].
- `clock` in 1: single clock for all logic.
- `resetn` in 1: reset, asynchronous, active-low.
- `s_awaddr` in AXI_ADDR_W; `s_awvalid` in 1; `s_awready` out 1: write address channel.
- `s_wdata` in 64; `s_wstrb` in 8; `s_wvalid` in 1; `s_wready` out 1: write data channel.
- `s_bresp` out 2; `s_bvalid` out 1; `s_bready` in 1: write response channel.
- `s_araddr` in AXI_ADDR_W; `s_arvalid` in 1; `s_arready` out 1: read address channel.
- `s_rdata` out 64; `s_rresp` out 2; `s_rvalid` out 1; `s_rready` in 1: read data channel.
- `write_addr` out 16; `write_data` out 64; `be` out 8; `we` out 1: bank write port, one-cycle strobe.
- `read_addr` out 16; `oe` out 1; `read_data` in 64: bank read port. Data is valid the cycle after `oe`.

## Operation
- FSM states: IDLE, WR_STB, WR_RESP, RD_STB, RD_CAP, RD_RESP. Exactly one transaction is in flight at a time.
- Write acceptance in IDLE:
  - A write is eligible only when `s_awvalid` and `s_wvalid` are both high.
  - `s_awready` and `s_wready` assert together in the same cycle; AW and W are never accepted separately.
- Read acceptance in IDLE: a read is eligible when `s_arvalid` is high.
- Arbitration when a write and a read are eligible in the same cycle:
  - Round-robin, using a `last_was_read` flag. Reset value 0, so the first contested grant goes to the read.
  - Uncontested requests are granted immediately.
- Ready signals are combinational from the IDLE state and the grant; they are 0 in every other state.
- On a write handshake, register:
  - `write_addr` = awaddr[18:3]
  - `write_data` = wdata
  - `be` = wstrb
- On a read handshake, register `read_addr` = araddr[18:3].
- Address bits [2:0] are ignored; there is no misalignment error.
- WR_STB: `we`=1 for exactly one cycle, then WR_RESP.
- WR_RESP: `s_bvalid`=1, held until `s_bready`, then IDLE.
- RD_STB: `oe`=1 for exactly one cycle.
- RD_CAP: sample `read_data` into `s_rdata`.
- RD_RESP: `s_rvalid`=1, held with `s_rdata` stable until `s_rready`, then IDLE.
- `s_bresp` and `s_rresp` are 2'b00 (OKAY) unless the range check applies.

## Timing
- Reset values (asynchronous):
  - State = IDLE.
  - `we`, `oe`, `s_bvalid`, `s_rvalid` = 0.
  - `write_addr`, `read_addr` = 0; `write_data`, `s_rdata` = 0; `be` = 0.
  - `s_bresp`, `s_rresp` = 0.
  - All readies = 0 while reset is asserted.
- Write latency: handshake at cycle T → `we` at T+1 → `s_bvalid` from T+2.
- Read latency: handshake at cycle T → `oe` at T+1 → capture at T+2 → `s_rvalid` from T+3.
- Back-to-back throughput:
  - The next handshake is possible in the cycle after `s_bready` or `s_rready` is accepted.
  - Minimum of 3 cycles per write and 4 cycles per read.
- Response stalls: `s_bready` or `s_rready` held low keeps the FSM in its RESP state indefinitely. No new request is accepted meanwhile.
- `we` and `oe` are never high in the same cycle.
- Reset asserted mid-transaction: the transaction is dropped, all outputs return to reset values immediately, and no strobe is issued after reset release.

## Configuration
- `ACCEL_BRIDGE_RANGE_CHECK_EN` defined:
  - A word index ≥ NUM_REGS yields response 2'b10 (SLVERR).
  - `we` and `oe` are suppressed for that transaction.
  - `s_rdata` = 0 for such a read.
  - Latency is unchanged.
- Macro undefined:
  - All responses are OKAY.
  - Out-of-range indices are forwarded to the bank unchanged.

## Structure
- Package `accel_bridge_pkg` holds:
  - The FSM state enum.
  - Response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - WORD_LSB=3 and IDX_W=16.
- Sub-module `accel_bridge_arb` is the two-requester round-robin arbiter. Inputs: write-eligible, read-eligible, IDLE qualifier. It owns the `last_was_read` flag and outputs the grants.

## Test plan
- Write 0x18 with data 0xDEADBEEF_01234567 and strb 0xFF → `we` one cycle with write_addr=3 and be=0xFF; `s_bvalid` at T+2 with bresp=0.
- Read 0x18 with the bank returning 0xDEADBEEF_01234567 on the cycle after `oe` → `s_rvalid` at T+3 with that rdata and rresp=0.
- AW and AR valid simultaneously immediately after reset → read served first, then the write; a second contested pair is served write first.
- AW valid without W for 5 cycles → no awready and no `we`; W arrives → both readies in the same cycle.
- `s_rready` held low for 10 cycles → rvalid and rdata stable, no further `oe`; `resetn` pulsed during RD_STB → all outputs at reset values, no response issued.
- With the macro defined, write to index 16 (addr 0x80) → no `we`, bresp=2'b10; without the macro → `we` with write_addr=16, bresp=0.

Source files
------------

// File: rtl/accel_bridge_pkg.sv
// Shared types and constants for the accel_axil_bridge slice: FSM state encoding,
// AXI response codes and the word-index geometry of the attached register bank.
package accel_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_STB,
      WR_RESP,
      RD_STB,
      RD_CAP,
      RD_RESP
   } bridge_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int WORD_LSB = 3;
   localparam int IDX_W    = 16;

endpackage

// File: rtl/accel_bridge_arb.sv
// Two-requester round-robin arbiter (write vs read) for the bridge's IDLE state.
// Uncontested requests win immediately; contested ones alternate via last_was_read.
module accel_bridge_arb (
   input  logic clock,
   input  logic resetn,
   input  logic i_wr_elig,
   input  logic i_rd_elig,
   input  logic i_idle,
   output logic o_wr_grant,
   output logic o_rd_grant
);

   logic r_last_was_read;

   always_comb begin
      o_rd_grant = i_idle & i_rd_elig & (~i_wr_elig | ~r_last_was_read);
      o_wr_grant = i_idle & i_wr_elig & (~i_rd_elig |  r_last_was_read);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_last_was_read <= 1'b0;
      end else if (o_rd_grant) begin
         r_last_was_read <= 1'b1;
      end else if (o_wr_grant) begin
         r_last_was_read <= 1'b0;
      end
   end

endmodule

// File: rtl/accel_axil_bridge.sv
// AXI4-Lite slave to single-cycle register-port bridge, one transaction in flight.
// Optional out-of-range SLVERR with strobe suppression: ACCEL_BRIDGE_RANGE_CHECK_EN.
module accel_axil_bridge
   import accel_bridge_pkg::*;
#(
   parameter int NUM_REGS   = 16,
   parameter int AXI_ADDR_W = 32
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic [AXI_ADDR_W-1:0] s_awaddr,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [63:0]           s_wdata,
   input  logic [7:0]            s_wstrb,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [1:0]            s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [AXI_ADDR_W-1:0] s_araddr,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [63:0]           s_rdata,
   output logic [1:0]            s_rresp,
   output logic                  s_rvalid,
   input  logic                  s_rready,
   output logic [15:0]           write_addr,
   output logic [63:0]           write_data,
   output logic [7:0]            be,
   output logic                  we,
   output logic [15:0]           read_addr,
   output logic                  oe,
   input  logic [63:0]           read_data
);

`ifdef ACCEL_BRIDGE_RANGE_CHECK_EN
   localparam logic RANGE_EN = 1'b1;
`else
   localparam logic RANGE_EN = 1'b0;
`endif
   localparam logic [IDX_W:0] NUM_REGS_EXT = (IDX_W + 1)'(NUM_REGS);

   bridge_state_t    r_state;
   bridge_state_t    w_state_next;
   logic [IDX_W-1:0] r_write_addr;
   logic [63:0]      r_write_data;
   logic [7:0]       r_be;
   logic [IDX_W-1:0] r_read_addr;
   logic [63:0]      r_rdata;
   logic [1:0]       r_bresp;
   logic [1:0]       r_rresp;
   logic             r_err;
   logic [IDX_W-1:0] w_aw_idx;
   logic [IDX_W-1:0] w_ar_idx;
   logic             w_aw_oob;
   logic             w_ar_oob;
   logic             w_idle;
   logic             w_wr_grant;
   logic             w_rd_grant;
   logic             w_unused;

   assign w_aw_idx = s_awaddr[WORD_LSB+IDX_W-1:WORD_LSB];
   assign w_ar_idx = s_araddr[WORD_LSB+IDX_W-1:WORD_LSB];
   assign w_aw_oob = RANGE_EN & ({1'b0, w_aw_idx} >= NUM_REGS_EXT);
   assign w_ar_oob = RANGE_EN & ({1'b0, w_ar_idx} >= NUM_REGS_EXT);
   assign w_unused = ^{s_awaddr[AXI_ADDR_W-1:WORD_LSB+IDX_W], s_awaddr[WORD_LSB-1:0],
                       s_araddr[AXI_ADDR_W-1:WORD_LSB+IDX_W], s_araddr[WORD_LSB-1:0]};

   // Gating with resetn keeps every ready low while reset is held.
   assign w_idle = (r_state == IDLE) & resetn;

   accel_bridge_arb u_arb (
      .clock      (clock),
      .resetn     (resetn),
      .i_wr_elig  (s_awvalid & s_wvalid),
      .i_rd_elig  (s_arvalid),
      .i_idle     (w_idle),
      .o_wr_grant (w_wr_grant),
      .o_rd_grant (w_rd_grant)
   );

   assign s_awready  = w_wr_grant;
   assign s_wready   = w_wr_grant;
   assign s_arready  = w_rd_grant;
   assign write_addr = r_write_addr;
   assign write_data = r_write_data;
   assign be         = r_be;
   assign read_addr  = r_read_addr;
   assign s_rdata    = r_rdata;
   assign s_bresp    = r_bresp;
   assign s_rresp    = r_rresp;

   always_comb begin
      w_state_next = r_state;
      we           = 1'b0;
      oe           = 1'b0;
      s_bvalid     = 1'b0;
      s_rvalid     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_wr_grant) begin
               w_state_next = WR_STB;
            end else if (w_rd_grant) begin
               w_state_next = RD_STB;
            end
         end
         WR_STB: begin
            we           = ~r_err;
            w_state_next = WR_RESP;
         end
         WR_RESP: begin
            s_bvalid = 1'b1;
            if (s_bready) w_state_next = IDLE;
         end
         RD_STB: begin
            oe           = ~r_err;
            w_state_next = RD_CAP;
         end
         RD_CAP: w_state_next = RD_RESP;
         RD_RESP: begin
            s_rvalid = 1'b1;
            if (s_rready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state      <= IDLE;
         r_write_addr <= '0;
         r_write_data <= '0;
         r_be         <= '0;
         r_read_addr  <= '0;
         r_rdata      <= '0;
         r_bresp      <= RESP_OKAY;
         r_rresp      <= RESP_OKAY;
         r_err        <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_wr_grant) begin
            r_write_addr <= w_aw_idx;
            r_write_data <= s_wdata;
            r_be         <= s_wstrb;
            r_err        <= w_aw_oob;
            r_bresp      <= w_aw_oob ? RESP_SLVERR : RESP_OKAY;
         end else if (w_rd_grant) begin
            r_read_addr <= w_ar_idx;
            r_err       <= w_ar_oob;
            r_rresp     <= w_ar_oob ? RESP_SLVERR : RESP_OKAY;
         end
         // Bank data is valid exactly one cycle after oe, i.e. while in RD_CAP.
         if (r_state == RD_CAP) begin
            r_rdata <= r_err ? 64'd0 : read_data;
         end
      end
   end

endmodule
